// File: rtl/monitor_output_collector.sv
// Captures timestamped frames of active monitor outputs into a FIFO and
// serialises them as one valid/ready record per active stream.
module monitor_output_collector #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_W      = 64,
    parameter int TS_W        = 32,
    parameter int DEPTH       = 8,
    localparam int IW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [IW-1:0]                 m_index,
    output logic [DATA_W-1:0]             m_data,
    output logic [TS_W-1:0]               m_ts,
    output logic [LW-1:0]                 fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    logic [TS_W-1:0]               ts_mem_r   [DEPTH];
    logic [NUM_OUTPUTS-1:0]        mask_mem_r [DEPTH];
    logic [NUM_OUTPUTS*DATA_W-1:0] data_mem_r [DEPTH];
    logic [AW-1:0]                 wr_ptr_r;
    logic [AW-1:0]                 rd_ptr_r;
    logic [LW-1:0]                 count_r;
    logic [TS_W-1:0]               ts_r;
    logic                          overflow_r;
    logic [15:0]                   drop_count_r;
    state_t                        state_r;
    logic [TS_W-1:0]               wts_r;
    logic [NUM_OUTPUTS-1:0]        wmask_r;
    logic [NUM_OUTPUTS*DATA_W-1:0] wdata_r;
    logic                          m_valid_r;
    logic [IW-1:0]                 m_index_r;
    logic [DATA_W-1:0]             m_data_r;
    logic [TS_W-1:0]               m_ts_r;

    logic                          capture_s;
    logic                          full_s;
    logic                          push_s;
    logic                          drop_s;
    logic                          pop_s;
    logic [NUM_OUTPUTS-1:0]        mask_rest_s;

    function automatic logic [IW-1:0] lowest_idx(input logic [NUM_OUTPUTS-1:0] mask);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (mask[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [DATA_W-1:0] stream_slice(input logic [NUM_OUTPUTS*DATA_W-1:0] d,
                                                       input logic [IW-1:0] idx);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (IW'(i) == idx) r = d[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    // Capture/pop decisions; fullness is judged before any same-edge pop.
    always_comb begin
        capture_s = en && (|out_aktv);
        full_s    = (count_r == LW'(DEPTH));
        push_s    = capture_s && !full_s;
        drop_s    = capture_s && full_s;
        pop_s     = (state_r == IDLE) && (count_r != {LW{1'b0}});
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            mask_rest_s[i] = wmask_r[i] && (IW'(i) != m_index_r);
        end
    end

    // Frame storage (no reset needed: contents are only read behind count_r).
    always_ff @(posedge clk) begin
        if (push_s) begin
            ts_mem_r[wr_ptr_r]   <= ts_r;
            mask_mem_r[wr_ptr_r] <= out_aktv;
            data_mem_r[wr_ptr_r] <= out_data;
        end
    end

    // FIFO pointers, occupancy, timestamp and drop accounting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {LW{1'b0}};
            ts_r         <= {TS_W{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            if (en) ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(LW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    // Serialiser: load a frame in IDLE, present one record per set mask bit in EMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            wts_r     <= {TS_W{1'b0}};
            wmask_r   <= {NUM_OUTPUTS{1'b0}};
            wdata_r   <= {(NUM_OUTPUTS*DATA_W){1'b0}};
            m_valid_r <= 1'b0;
            m_index_r <= {IW{1'b0}};
            m_data_r  <= {DATA_W{1'b0}};
            m_ts_r    <= {TS_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    m_valid_r <= 1'b0;
                    if (pop_s) begin
                        wts_r   <= ts_mem_r[rd_ptr_r];
                        wmask_r <= mask_mem_r[rd_ptr_r];
                        wdata_r <= data_mem_r[rd_ptr_r];
                        state_r <= EMIT;
                    end
                end
                EMIT: begin
                    if (!m_valid_r) begin
                        m_valid_r <= 1'b1;
                        m_index_r <= lowest_idx(wmask_r);
                        m_data_r  <= stream_slice(wdata_r, lowest_idx(wmask_r));
                        m_ts_r    <= wts_r;
                    end else if (m_ready) begin
                        wmask_r <= mask_rest_s;
                        if (mask_rest_s == {NUM_OUTPUTS{1'b0}}) begin
                            m_valid_r <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            m_index_r <= lowest_idx(mask_rest_s);
                            m_data_r  <= stream_slice(wdata_r, lowest_idx(mask_rest_s));
                        end
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign m_valid    = m_valid_r;
    assign m_index    = m_index_r;
    assign m_data     = m_data_r;
    assign m_ts       = m_ts_r;
    assign fifo_level = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_monitor_output_collector.sv
// Directed bench for monitor_output_collector: a cycle table for the basic
// record flow plus hand-written backpressure, overflow, gating and reset runs.
module tb_monitor_output_collector;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] out_data;
    logic [1:0]   out_aktv;
    logic         m_valid;
    logic         m_ready;
    logic [0:0]   m_index;
    logic [63:0]  m_data;
    logic [31:0]  m_ts;
    logic [3:0]   fifo_level;
    logic         overflow;
    logic [15:0]  drop_count;

    int tests;
    int failed;
    int xfers;

    monitor_output_collector #(
        .NUM_OUTPUTS(2), .DATA_W(64), .TS_W(32), .DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
        .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_data(m_data),
        .m_ts(m_ts), .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && m_valid && m_ready) xfers <= xfers + 1;
    end

    typedef struct {
        logic        en;
        logic [1:0]  aktv;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        ready;
        logic        exp_valid;
        logic        exp_idx;
        logic [63:0] exp_data;
        logic [31:0] exp_ts;
        logic [3:0]  exp_level;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [31:0] q_ts   [$];
    logic [63:0] q_data [$];
    int          x0;
    int          vcount;

    initial begin
        tests = 0; failed = 0; xfers = 0;
        rst = 1'b0; en = 1'b0; out_data = 128'd0; out_aktv = 2'b00; m_ready = 1'b1;
        #2;
        chk("reset m_valid", {63'd0, m_valid}, 64'd0);
        chk("reset fifo_level", {60'd0, fifo_level}, 64'd0);
        chk("reset overflow", {63'd0, overflow}, 64'd0);
        chk("reset drop_count", {48'd0, drop_count}, 64'd0);
        chk("reset m_ts", {32'd0, m_ts}, 64'd0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            vecs[i] = '{en: 1'b1, aktv: 2'b00, d0: 64'd0, d1: 64'd0, ready: 1'b1,
                        exp_valid: 1'b0, exp_idx: 1'b0, exp_data: 64'd0,
                        exp_ts: 32'd0, exp_level: 4'd0};
        end
        vecs[5].aktv = 2'b01;  vecs[5].d0 = 64'd1;  vecs[5].exp_level = 4'd1;
        vecs[7].exp_valid = 1'b1; vecs[7].exp_data = 64'd1; vecs[7].exp_ts = 32'd5;
        vecs[20].aktv = 2'b11; vecs[20].d0 = 64'd7;
        vecs[20].d1 = 64'hFFFF_FFFF_FFFF_FFF7; vecs[20].exp_level = 4'd1;
        vecs[22].exp_valid = 1'b1; vecs[22].exp_idx = 1'b0;
        vecs[22].exp_data = 64'd7; vecs[22].exp_ts = 32'd20;
        vecs[23].exp_valid = 1'b1; vecs[23].exp_idx = 1'b1;
        vecs[23].exp_data = 64'hFFFF_FFFF_FFFF_FFF7; vecs[23].exp_ts = 32'd20;

        for (int i = 0; i < 25; i++) begin
            en = vecs[i].en; out_aktv = vecs[i].aktv;
            out_data = {vecs[i].d1, vecs[i].d0}; m_ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d m_valid", i), {63'd0, m_valid}, {63'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d fifo_level", i), {60'd0, fifo_level}, {60'd0, vecs[i].exp_level});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d m_index", i), {63'd0, m_index}, {63'd0, vecs[i].exp_idx});
                chk($sformatf("vec%0d m_data", i), m_data, vecs[i].exp_data);
                chk($sformatf("vec%0d m_ts", i), {32'd0, m_ts}, {32'd0, vecs[i].exp_ts});
            end
        end

        // Backpressure: one record held for 10 cycles, then exactly one transfer.
        m_ready = 1'b0; out_aktv = 2'b01; out_data = {64'd0, 64'h55};
        tick();
        out_aktv = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp m_valid held", {63'd0, m_valid}, 64'd1);
            chk("bp m_data held", m_data, 64'h55);
            chk("bp m_ts held", {32'd0, m_ts}, 64'd25);
            tick();
        end
        x0 = xfers;
        m_ready = 1'b1;
        tick();
        chk("bp m_valid after accept", {63'd0, m_valid}, 64'd0);
        repeat (4) tick();
        chk("bp transfer count", 64'(xfers - x0), 64'd1);

        // Overflow: 11 captures into an 8-deep FIFO with the sink stalled.
        en = 1'b1; m_ready = 1'b0;
        reset_pulse();
        for (int i = 0; i < 11; i++) begin
            out_aktv = 2'b01; out_data = {64'd0, 64'(i)};
            tick();
            chk($sformatf("ovf level edge%0d", i), {60'd0, fifo_level},
                (i == 0) ? 64'd1 : ((i > 8) ? 64'd8 : 64'(i)));
        end
        out_aktv = 2'b00;
        chk("ovf overflow", {63'd0, overflow}, 64'd1);
        chk("ovf drop_count", {48'd0, drop_count}, 64'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (m_valid) begin
                q_ts.push_back(m_ts);
                q_data.push_back(m_data);
            end
            tick();
        end
        chk("ovf record count", 64'(q_ts.size()), 64'd9);
        for (int k = 0; k < q_ts.size() && k < 9; k++) begin
            chk($sformatf("ovf rec%0d ts", k), {32'd0, q_ts[k]}, 64'(k));
            chk($sformatf("ovf rec%0d data", k), q_data[k], 64'(k));
        end
        chk("ovf level drained", {60'd0, fifo_level}, 64'd0);

        // Enable gating: ts must freeze and out_aktv be ignored while en=0.
        reset_pulse();
        out_aktv = 2'b00;
        repeat (3) tick();
        en = 1'b0; vcount = 0;
        for (int i = 0; i < 50; i++) begin
            out_aktv = i[0] ? 2'b11 : 2'b01; out_data = {64'(i), 64'(i)};
            tick();
            if (m_valid) vcount++;
        end
        chk("gate no records", 64'(vcount), 64'd0);
        chk("gate level", {60'd0, fifo_level}, 64'd0);
        en = 1'b1; out_aktv = 2'b01; out_data = {64'd0, 64'hAB};
        tick();
        out_aktv = 2'b00;
        for (int k = 0; k < 10 && !m_valid; k++) tick();
        chk("gate record seen", {63'd0, m_valid}, 64'd1);
        chk("gate held ts", {32'd0, m_ts}, 64'd3);
        chk("gate data", m_data, 64'hAB);

        // Asynchronous reset in the middle of an emission.
        m_ready = 1'b0;
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            out_aktv = 2'b11; out_data = {64'(i + 100), 64'(i)};
            tick();
        end
        out_aktv = 2'b00;
        chk("ar pre m_valid", {63'd0, m_valid}, 64'd1);
        chk("ar pre overflow", {63'd0, overflow}, 64'd1);
        chk("ar pre drop_count", {48'd0, drop_count}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar m_valid", {63'd0, m_valid}, 64'd0);
        chk("ar fifo_level", {60'd0, fifo_level}, 64'd0);
        chk("ar overflow", {63'd0, overflow}, 64'd0);
        chk("ar drop_count", {48'd0, drop_count}, 64'd0);
        tick();
        rst = 1'b1; m_ready = 1'b1; out_aktv = 2'b10; out_data = {64'h77, 64'd0};
        tick();
        out_aktv = 2'b00;
        x0 = xfers;
        for (int k = 0; k < 10 && !m_valid; k++) tick();
        chk("ar post m_valid", {63'd0, m_valid}, 64'd1);
        chk("ar post m_index", {63'd0, m_index}, 64'd1);
        chk("ar post m_data", m_data, 64'h77);
        chk("ar post m_ts", {32'd0, m_ts}, 64'd0);
        repeat (6) tick();
        chk("ar post transfers", 64'(xfers - x0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
